// File: rtl/core_mem_pkg.sv
// Shared definitions for the RV32I core memory ports: port indices, SRAM window,
// issue-slot record and read-lane masking.
package core_mem_pkg;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam logic [7:0] DEFAULT_WINDOW_LO = 8'h00;
  localparam logic [7:0] DEFAULT_WINDOW_HI = 8'h80;
  localparam int         DEFAULT_MAX_WAIT  = 4;

  typedef struct packed {
    logic valid;
    logic port;
    logic fault;
  } slot_t;

  function automatic logic [31:0] laneMask(input logic [3:0] byteSelect);
    return {{8{byteSelect[3]}}, {8{byteSelect[2]}}, {8{byteSelect[1]}}, {8{byteSelect[0]}}};
  endfunction

endpackage

// File: rtl/sram_window_decode.sv
// Splits a core byte address into the SRAM-local address and a flag saying
// whether the top byte selects one of the two accepted SRAM windows.
module sram_window_decode
  import core_mem_pkg::*;
#(
  parameter int         ADDR_WIDTH = 24,
  parameter logic [7:0] WINDOW_LO  = DEFAULT_WINDOW_LO,
  parameter logic [7:0] WINDOW_HI  = DEFAULT_WINDOW_HI
) (
  input  logic [31:0]           address,
  output logic                  inWindow,
  output logic [ADDR_WIDTH-1:0] localAddress
);

  assign inWindow     = (address[31:24] == WINDOW_LO) || (address[31:24] == WINDOW_HI);
  assign localAddress = address[ADDR_WIDTH-1:0];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between the fetch and data ports
// of the core; data has priority, bounded by an instruction anti-starvation count.
//
// phase | meaning
// WAIT  | port enable high, no slot holds this port yet
// ISSUE | issue slot holds this port; SRAM driven from its held request
// RESP  | response slot holds this port; busy low, data or fault presented
module sram_port_arbiter
  import core_mem_pkg::*;
#(
  parameter int         ADDR_WIDTH = 24,
  parameter logic [7:0] WINDOW_LO  = DEFAULT_WINDOW_LO,
  parameter logic [7:0] WINDOW_HI  = DEFAULT_WINDOW_HI,
  parameter int         MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clock,
  input  logic                  RSTB,
  input  logic [31:0]           instruction_memoryAddress,
  input  logic                  instruction_memoryEnable,
  output logic [31:0]           instruction_memoryDataRead,
  output logic                  instruction_memoryBusy,
  output logic                  instruction_memoryAccessFault,
  input  logic [31:0]           data_memoryAddress,
  input  logic [3:0]            data_memoryByteSelect,
  input  logic                  data_memoryEnable,
  input  logic                  data_memoryWriteEnable,
  input  logic [31:0]           data_memoryDataWrite,
  output logic [31:0]           data_memoryDataRead,
  output logic                  data_memoryBusy,
  output logic                  data_memoryAccessFault,
  output logic                  sram_enable,
  output logic                  sram_writeEnable,
  output logic [3:0]            sram_byteSelect,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [31:0]           sram_dataWrite,
  input  logic [31:0]           sram_dataRead,
  output logic [1:0]            probe_grant
);

  localparam logic [2:0] WAIT_LIMIT = 3'(MAX_WAIT);

  slot_t issue, issueNext, resp;
  logic        respWrite;
  logic [3:0]  respByteSelect;
  logic [2:0]  instWaitCnt, instWaitNext;

  logic                  instInWindow, dataInWindow;
  logic [ADDR_WIDTH-1:0] instLocal, dataLocal;
  logic                  instCand, dataCand;
  logic                  issueIsData, instResp, dataResp;

  sram_window_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .WINDOW_LO(WINDOW_LO), .WINDOW_HI(WINDOW_HI)
  ) u_instDecode (
    .address(instruction_memoryAddress), .inWindow(instInWindow), .localAddress(instLocal)
  );

  sram_window_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .WINDOW_LO(WINDOW_LO), .WINDOW_HI(WINDOW_HI)
  ) u_dataDecode (
    .address(data_memoryAddress), .inWindow(dataInWindow), .localAddress(dataLocal)
  );

  always_ff @(posedge clock) begin
    if (!RSTB) begin
      issue          <= '0;
      resp           <= '0;
      respWrite      <= 1'b0;
      respByteSelect <= '0;
      instWaitCnt    <= '0;
    end else begin
      issue          <= issueNext;
      resp           <= issue;
      respWrite      <= (issue.port == PORT_DATA) && data_memoryWriteEnable;
      respByteSelect <= data_memoryByteSelect;
      instWaitCnt    <= instWaitNext;
    end
  end

  // A port already holding the issue or response slot cannot be picked again,
  // so alternating ports pipeline at one access per cycle.
  always_comb begin
    instCand = instruction_memoryEnable
               && !(issue.valid && issue.port == PORT_INST)
               && !(resp.valid  && resp.port  == PORT_INST);
    dataCand = data_memoryEnable
               && !(issue.valid && issue.port == PORT_DATA)
               && !(resp.valid  && resp.port  == PORT_DATA);
    issueNext    = '0;
    instWaitNext = instWaitCnt;
    if (instCand && (!dataCand || instWaitCnt == WAIT_LIMIT)) begin
      issueNext.valid = 1'b1;
      issueNext.port  = PORT_INST;
      issueNext.fault = !instInWindow;
      instWaitNext    = '0;
    end else if (dataCand) begin
      issueNext.valid = 1'b1;
      issueNext.port  = PORT_DATA;
      issueNext.fault = !dataInWindow;
      if (instCand) instWaitNext = instWaitCnt + 3'd1;
    end
    if (!instruction_memoryEnable) instWaitNext = '0;
  end

  // Everything core- or SRAM-visible is gated by RSTB so a held reset masks slots
  // that have not been cleared by a clock edge yet.
  always_comb begin
    issueIsData      = issue.port == PORT_DATA;
    sram_enable      = RSTB && issue.valid && !issue.fault;
    sram_writeEnable = sram_enable && issueIsData && data_memoryWriteEnable;
    sram_byteSelect  = issueIsData ? data_memoryByteSelect : 4'b1111;
    sram_address     = issueIsData ? dataLocal : instLocal;
    sram_dataWrite   = data_memoryDataWrite;

    instResp = RSTB && resp.valid && resp.port == PORT_INST;
    dataResp = RSTB && resp.valid && resp.port == PORT_DATA;

    instruction_memoryBusy        = instruction_memoryEnable && !instResp;
    instruction_memoryAccessFault = instResp && resp.fault;
    instruction_memoryDataRead    = (instResp && !resp.fault) ? sram_dataRead : '0;

    data_memoryBusy        = data_memoryEnable && !dataResp;
    data_memoryAccessFault = dataResp && resp.fault;
    data_memoryDataRead    = (dataResp && !resp.fault && !respWrite)
                             ? (sram_dataRead & laneMask(respByteSelect)) : '0;

    probe_grant = {issue.valid, issue.valid && issueIsData};
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one single-port, 1-cycle-latency SRAM between the RV32I core's instruction-fetch port and data port. Presents core-side busy/accessFault handshakes, decodes the SRAM address window, and issues at most one SRAM access per cycle. Data has fixed priority, bounded by an instruction anti-starvation counter. It sits between RV32ICore and the shared SRAM macro or model.

Parameters:
ADDR_WIDTH, 24, SRAM byte-address width; local address = memoryAddress[ADDR_WIDTH-1:0]
WINDOW_LO, 8'h00, first accepted value of memoryAddress[31:24]
WINDOW_HI, 8'h80, second accepted value of memoryAddress[31:24]
MAX_WAIT, 4, consecutive instruction-waiting cycles after which instruction wins the next grant

Ports:
clock  in  1  system clock, rising edge
RSTB  in  1  reset, synchronous, active-low
instruction_memoryAddress  in  32  fetch byte address
instruction_memoryEnable  in  1  fetch request, held until served
instruction_memoryDataRead  out  32  fetch data, valid in response cycle
instruction_memoryBusy  out  1  request not yet served
instruction_memoryAccessFault  out  1  out-of-window fetch, response cycle only
data_memoryAddress  in  32  data byte address
data_memoryByteSelect  in  4  byte lanes
data_memoryEnable  in  1  data request, held until served
data_memoryWriteEnable  in  1  1 = write
data_memoryDataWrite  in  32  write data
data_memoryDataRead  out  32  read data, unselected lanes forced 0
data_memoryBusy  out  1  request not yet served
data_memoryAccessFault  out  1  out-of-window access, response cycle only
sram_enable  out  1  SRAM access strobe
sram_writeEnable  out  1  SRAM write
sram_byteSelect  out  4  SRAM lanes (4'b1111 for fetch)
sram_address  out  ADDR_WIDTH  SRAM byte address
sram_dataWrite  out  32  SRAM write data
sram_dataRead  in  32  SRAM read data, valid the cycle after sram_enable
probe_grant  out  2  {issue_valid, issue_is_data}, for debug

Behaviour:
- Per-port phases: WAIT (enable high, not issued), ISSUE (SRAM driven for that port), RESP (one cycle; busy low, data or fault presented).
- Registered issue slot: issue_valid, issue_port, issue_fault. RESP is the cycle after ISSUE.
- sram_* outputs are combinational from the registered issue slot and the held request. sram_enable = issue_valid && !issue_fault. sram_dataWrite and sram_byteSelect are passed through.
- Arbitration runs every cycle over candidates: enable high, port not in ISSUE, port not in RESP. If both are candidates, data wins unless inst_wait_cnt == MAX_WAIT.
- Pipelining: while port X is in ISSUE, port Y != X may be selected, so its ISSUE overlaps X's RESP. Alternating ports give one access per cycle. The same port re-issues no earlier than the cycle after its RESP.
- Latency with no contention: enable rises in cycle 0, grant is registered, ISSUE is cycle 1, RESP is cycle 2.
- busy = enable && !(port in RESP).
- dataRead = sram_dataRead in RESP, else 32'b0. For data reads, lanes are masked by byteSelect. For writes, dataRead is 0.
- Window fault: addr[31:24] not equal to WINDOW_LO or WINDOW_HI. The request is granted normally, but sram_enable stays 0 in ISSUE. RESP asserts accessFault=1 and dataRead=0 for one cycle.
- inst_wait_cnt, 3 bits:
  - increments (saturating at MAX_WAIT) each cycle the instruction port is a candidate but data is selected;
  - clears when instruction is selected or instruction enable is low.
- A request dropped while in WAIT is abandoned with no SRAM access. A request dropped during ISSUE still completes: the SRAM access happens and the RESP pulse is driven and ignored.
- Reset (RSTB low at a clock edge):
  - issue slot, RESP flags and inst_wait_cnt clear;
  - during reset, sram_enable=0, dataRead=0, accessFault=0, busy = enable;
  - reset mid-access aborts it with no RESP;
  - first grant is possible the cycle after RSTB rises.

Decomposition:
- Shared package core_mem_pkg:
  - port index constants PORT_INST=0, PORT_DATA=1;
  - window constants;
  - byte-lane mask function for read masking.
- One natural sub-module: sram_window_decode (address → in_window, local address), instanced once per port.

Test Plan:
1. Fetch only, memory[0x000100]=0x00000013. Fetch addr 0x00000100 → busy high for 2 cycles, RESP cycle dataRead=0x00000013, busy low, sram_byteSelect=4'b1111.
2. Data write 0x80000200, byteSelect 4'b0011, dataWrite 0xAABBCCDD, then read back with byteSelect 4'b1111 → memory lanes 0x200/0x201 = DD/CC, readback low half 0xCCDD, upper bytes unchanged.
3. Simultaneous fetch 0x0 and data read 0x10 → data ISSUE cycle 1, fetch ISSUE cycle 2 overlapping data RESP, fetch RESP cycle 3, exactly one sram_enable per cycle.
4. Data back-to-back for 10 cycles with fetch pending, MAX_WAIT=4 → fetch granted no later than the 5th cycle of waiting, inst_wait_cnt then 0.
5. Data read 0x40000000 → no sram_enable, RESP accessFault=1 for one cycle, dataRead=0, busy low.
6. RSTB low during fetch ISSUE → no RESP pulse, outputs 0. After RSTB high with enable still high → fresh ISSUE next cycle, correct data.
